// File: rtl/gate_pkg.sv
// Shared types, defaults and the passage state machine transition function
// for the gate sensor decoder.
package gate_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF  = 64;

    // Bits needed to hold a counter running from 0 to n-1 (at least one bit).
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ENT_A,
        ENT_AB,
        ENT_B,
        EXT_B,
        EXT_AB,
        EXT_A,
        WAIT_CLEAR
    } gate_state_t;

    // Outcome of one FSM step: where to go and which event it produces.
    typedef struct packed {
        gate_state_t next;
        logic        fault;
        logic        entry_done;
        logic        exit_done;
    } gate_step_t;

    // True in the states where a car is part way through the gate.
    function automatic logic in_passage(input gate_state_t s);
        return (s != IDLE) && (s != WAIT_CLEAR);
    endfunction

    // Next state and event for the current state and debounced beams (da, db).
    function automatic gate_step_t gate_step(input gate_state_t s,
                                             input logic        da,
                                             input logic        db,
                                             input logic        timed_out);
        gate_step_t r;
        // NOTE: every field gets a default before the case, so no path leaves
        // it unassigned; in combinational logic a missed path infers a latch.
        r.next       = s;
        r.fault      = 1'b0;
        r.entry_done = 1'b0;
        r.exit_done  = 1'b0;
        if (timed_out && in_passage(s)) begin
            r.next  = WAIT_CLEAR;
            r.fault = 1'b1;
        end else begin
            case (s)
                IDLE: case ({da, db})
                    2'b10: r.next = ENT_A;
                    2'b01: r.next = EXT_B;
                    2'b11: begin r.next = WAIT_CLEAR; r.fault = 1'b1; end
                    default: ;
                endcase
                ENT_A: case ({da, db})
                    2'b11: r.next = ENT_AB;
                    2'b00: r.next = IDLE;
                    2'b01: begin r.next = WAIT_CLEAR; r.fault = 1'b1; end
                    default: ;
                endcase
                ENT_AB: case ({da, db})
                    2'b01: r.next = ENT_B;
                    2'b10: r.next = ENT_A;
                    2'b00: begin r.next = IDLE; r.fault = 1'b1; end
                    default: ;
                endcase
                ENT_B: case ({da, db})
                    2'b00: begin r.next = IDLE; r.entry_done = 1'b1; end
                    2'b11: r.next = ENT_AB;
                    2'b10: begin r.next = WAIT_CLEAR; r.fault = 1'b1; end
                    default: ;
                endcase
                EXT_B: case ({da, db})
                    2'b11: r.next = EXT_AB;
                    2'b00: r.next = IDLE;
                    2'b10: begin r.next = WAIT_CLEAR; r.fault = 1'b1; end
                    default: ;
                endcase
                EXT_AB: case ({da, db})
                    2'b10: r.next = EXT_A;
                    2'b01: r.next = EXT_B;
                    2'b00: begin r.next = IDLE; r.fault = 1'b1; end
                    default: ;
                endcase
                EXT_A: case ({da, db})
                    2'b00: begin r.next = IDLE; r.exit_done = 1'b1; end
                    2'b11: r.next = EXT_AB;
                    2'b01: begin r.next = WAIT_CLEAR; r.fault = 1'b1; end
                    default: ;
                endcase
                WAIT_CLEAR: if ({da, db} == 2'b00) r.next = IDLE;
                default: r.next = IDLE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a debouncer: the clean output follows the
// synchronized input only after it has disagreed for DEBOUNCE_CYCLES cycles.
module input_debouncer
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int              CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw beam, then count consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so the two sync stages really are two stages.
            sync <= {sync[0], raw};
            if (sync[1] == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_sensor_decoder.sv
// Turns the street-side (A) and lot-side (B) beam sensors into single-cycle
// entry / exit / reject / fault pulses based on the order beams break and clear.
module gate_sensor_decoder
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    input  logic lot_full,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic reject_pulse,
    output logic fault_pulse,
    output logic busy
);

    localparam int               DWELL_W    = count_width(TIMEOUT_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(TIMEOUT_CYCLES - 1);

    logic              da;
    logic              db;
    gate_state_t       state;
    logic [DWELL_W-1:0] dwell;
    logic              timed_out;
    gate_step_t        step;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_a),
        .clean (da)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_b),
        .clean (db)
    );

    assign timed_out = (dwell == DWELL_LAST);
    assign step      = gate_step(state, da, db, timed_out);

    // Passage FSM with dwell timer; pulses are registered alongside the state
    // so each appears the cycle after its transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dwell        <= '0;
            entry_pulse  <= 1'b0;
            exit_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
            fault_pulse  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= step.next;
            busy         <= (step.next != IDLE);
            fault_pulse  <= step.fault;
            entry_pulse  <= step.entry_done && !lot_full;
            reject_pulse <= step.entry_done && lot_full;
            exit_pulse   <= step.exit_done;
            if ((step.next != state) || !in_passage(state)) begin
                dwell <= '0;
            end else if (dwell != DWELL_LAST) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder: entry, exit, full-lot reject,
// bounce rejection, back-out, timeout, illegal jump and mid-passage reset.
module tb_gate_sensor_decoder;
    import gate_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic sensor_a;
    logic sensor_b;
    logic lot_full;
    logic entry_pulse;
    logic exit_pulse;
    logic reject_pulse;
    logic fault_pulse;
    logic busy;

    always #5 clk = ~clk;

    gate_sensor_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_a     (sensor_a),
        .sensor_b     (sensor_b),
        .lot_full     (lot_full),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .reject_pulse (reject_pulse),
        .fault_pulse  (fault_pulse),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse tallies and a downstream car counter, sampled mid-cycle.
    int n_entry = 0, n_exit = 0, n_reject = 0, n_fault = 0, n_multi = 0;
    int car_count = 3;
    always @(negedge clk) begin
        #1;
        if (entry_pulse === 1'b1) n_entry++;
        if (exit_pulse === 1'b1) begin n_exit++; car_count--; end
        if (reject_pulse === 1'b1) n_reject++;
        if (fault_pulse === 1'b1) n_fault++;
        if ((int'(entry_pulse) + int'(exit_pulse) + int'(reject_pulse) + int'(fault_pulse)) > 1)
            n_multi++;
    end

    int e0, x0, r0, f0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        e0 = n_entry; x0 = n_exit; r0 = n_reject; f0 = n_fault;
    endtask

    initial begin
        reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0; lot_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_entry", entry_pulse, 0);
        check("rst_exit", exit_pulse, 0);
        check("rst_reject", reject_pulse, 0);
        check("rst_fault", fault_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Normal entry, lot not full.
        snap();
        drive(1, 0, 10); check("ent_busy_a", busy, 1); check("ent_state_a", dut.state, ENT_A);
        drive(1, 1, 10); check("ent_busy_ab", busy, 1); check("ent_state_ab", dut.state, ENT_AB);
        drive(0, 1, 10); check("ent_busy_b", busy, 1); check("ent_state_b", dut.state, ENT_B);
        sensor_a = 1'b0; sensor_b = 1'b0;
        repeat (6) @(negedge clk);
        check("ent_pulse_early", entry_pulse, 0);
        @(negedge clk);
        check("ent_pulse_at7", entry_pulse, 1);
        check("ent_busy_done", busy, 0);
        @(negedge clk);
        check("ent_pulse_late", entry_pulse, 0);
        repeat (4) @(negedge clk);
        check("ent_count", n_entry - e0, 1);
        check("ent_no_exit", n_exit - x0, 0);
        check("ent_no_reject", n_reject - r0, 0);
        check("ent_no_fault", n_fault - f0, 0);

        // Exit, feeding a downstream counter that starts at three cars.
        snap();
        drive(0, 1, 10); check("ext_state_b", dut.state, EXT_B);
        drive(1, 1, 10); check("ext_state_ab", dut.state, EXT_AB);
        drive(1, 0, 10); check("ext_state_a", dut.state, EXT_A);
        drive(0, 0, 10);
        check("ext_count", n_exit - x0, 1);
        check("ext_no_entry", n_entry - e0, 0);
        check("ext_no_fault", n_fault - f0, 0);
        check("ext_car_count", car_count, 2);
        check("ext_busy_done", busy, 0);

        // Entry while the lot is full becomes a rejection.
        snap();
        lot_full = 1'b1;
        drive(1, 0, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        sensor_a = 1'b0; sensor_b = 1'b0;
        repeat (7) @(negedge clk);
        check("full_reject_at7", reject_pulse, 1);
        check("full_entry_at7", entry_pulse, 0);
        repeat (5) @(negedge clk);
        lot_full = 1'b0;
        check("full_reject_count", n_reject - r0, 1);
        check("full_entry_count", n_entry - e0, 0);

        // Bounce on A: three one-cycle toggles must never reach da.
        snap();
        sensor_a = 1'b1; @(negedge clk);
        sensor_a = 1'b0; @(negedge clk);
        sensor_a = 1'b1; @(negedge clk);
        sensor_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("bounce_da", dut.da, 0);
        end
        check("bounce_busy", busy, 0);

        // Back-out: A, AB, A, clear returns to IDLE with no pulse.
        drive(1, 0, 10);
        drive(1, 1, 10); check("backout_state_ab", dut.state, ENT_AB);
        drive(1, 0, 10); check("backout_state_a", dut.state, ENT_A);
        drive(0, 0, 10);
        check("backout_state_idle", dut.state, IDLE);
        check("backout_busy", busy, 0);
        check("backout_pulses", (n_entry - e0) + (n_exit - x0) + (n_reject - r0) + (n_fault - f0), 0);

        // Timeout: both beams held from ENT_AB for 100 cycles.
        snap();
        drive(1, 0, 10);
        sensor_a = 1'b1; sensor_b = 1'b1;
        repeat (70) @(negedge clk);
        check("tmo_fault_early", fault_pulse, 0);
        @(negedge clk);
        check("tmo_fault_at64", fault_pulse, 1);
        check("tmo_state_wait", dut.state, WAIT_CLEAR);
        repeat (29) @(negedge clk);
        check("tmo_busy_held", busy, 1);
        check("tmo_state_held", dut.state, WAIT_CLEAR);
        sensor_a = 1'b0; sensor_b = 1'b0;
        repeat (6) @(negedge clk);
        check("tmo_busy_before_clear", busy, 1);
        @(negedge clk);
        check("tmo_busy_cleared", busy, 0);
        check("tmo_state_idle", dut.state, IDLE);
        check("tmo_fault_count", n_fault - f0, 1);
        repeat (4) @(negedge clk);

        // Illegal jump: both beams break together from IDLE.
        snap();
        sensor_a = 1'b1; sensor_b = 1'b1;
        repeat (6) @(negedge clk);
        check("jump_fault_early", fault_pulse, 0);
        @(negedge clk);
        check("jump_fault", fault_pulse, 1);
        check("jump_state_wait", dut.state, WAIT_CLEAR);
        drive(0, 0, 10);
        check("jump_busy_done", busy, 0);
        check("jump_fault_count", n_fault - f0, 1);

        // Reset while in ENT_B aborts the passage.
        snap();
        drive(1, 0, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        check("mid_state_b", dut.state, ENT_B);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", dut.state, IDLE);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_db", dut.db, 0);
        check("mid_rst_pulses", {entry_pulse, exit_pulse, reject_pulse, fault_pulse}, 0);
        reset = 1'b0;
        drive(0, 1, 10);
        drive(0, 0, 10);
        check("mid_no_entry", n_entry - e0, 0);
        check("mid_no_exit", n_exit - x0, 0);
        check("mid_busy_done", busy, 0);

        check("pulse_exclusive", n_multi, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_sensor_decoder.md
Name: gate_sensor_decoder

Overview:
- Upstream stage of smart_parking_lot. Converts two raw, bouncy beam sensors at the lot gate into clean single-cycle entry/exit pulses, which drive smart_parking_lot entry_button/exit_button.
- Sensor A is on the street side; sensor B is on the lot side. Direction is taken from the order in which the beams break and clear.
- When the lot is full, completed entries are reported as rejections instead.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a debounced sensor changes value.
- TIMEOUT_CYCLES, 64: maximum cycles spent in one mid-passage state before abort.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sensor_a  input  1  raw street-side beam, 1 = broken, asynchronous.
- sensor_b  input  1  raw lot-side beam, 1 = broken, asynchronous.
- lot_full  input  1  driven from smart_parking_lot full_led.
- entry_pulse  output  1  one-cycle pulse on each completed entry while not full.
- exit_pulse  output  1  one-cycle pulse on each completed exit.
- reject_pulse  output  1  one-cycle pulse on a completed entry while lot_full = 1.
- fault_pulse  output  1  one-cycle pulse on timeout or illegal sensor jump.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-high; the polarity and synchronicity are fixed. All outputs are 0. FSM goes to IDLE. Synchronizers, debounced values and all counters clear to 0. Reset asserted mid-passage aborts the passage with no pulse.
- Input path: each sensor passes through a 2-flop synchronizer and then a debouncer. The debounced value (da, db) takes the synced value once the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles. The debounce counter clears on any agreement cycle.
- Latency: a stable raw change is reflected in da/db exactly 2 + DEBOUNCE_CYCLES cycles later. All pulses are registered and assert the cycle after the FSM transition that produces them.
- FSM states: IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A, WAIT_CLEAR. Transitions below are written as (da,db).
- IDLE: 10 -> ENT_A; 01 -> EXT_B; 11 -> WAIT_CLEAR with fault_pulse; 00 -> stay.
- ENT_A: 11 -> ENT_AB; 00 -> IDLE (car backed out, no pulse); 01 -> WAIT_CLEAR with fault.
- ENT_AB: 01 -> ENT_B; 10 -> ENT_A; 00 -> IDLE with fault.
- ENT_B: 00 -> IDLE, then entry_pulse if lot_full = 0, else reject_pulse; 11 -> ENT_AB; 10 -> WAIT_CLEAR with fault.
- EXT_B, EXT_AB, EXT_A: mirror of the entry states with A and B swapped. Completion from EXT_A on 00 gives exit_pulse, regardless of lot_full.
- WAIT_CLEAR: 00 -> IDLE; anything else -> stay. No pulses are issued from this state.
- lot_full is sampled in the same cycle as the completing transition.
- Timeout: a dwell counter clears on every state change. It counts only in ENT_*/EXT_* states. When it reaches TIMEOUT_CYCLES - 1 the FSM goes to WAIT_CLEAR with fault_pulse. The counter saturates and never wraps.
- Exclusivity: entry_pulse, exit_pulse, reject_pulse and fault_pulse are mutually exclusive; at most one is high in any cycle.
- Consecutive cars: a new passage starts from IDLE on the next cycle. There is no dead time beyond debounce.

Decomposition:
- Package gate_pkg holds:
  - the state enum gate_state_t;
  - default constants DEBOUNCE_CYCLES_DEF and TIMEOUT_CYCLES_DEF;
  - counter widths via $clog2.
- Sub-module input_debouncer (synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES) is instantiated once per sensor. The FSM and pulse registers live in the top.

Test Plan:
- Entry: after reset, drive raw A=1; then A=1,B=1; then A=0,B=1; then both 0, holding each step for 10 cycles with lot_full = 0. Expect exactly one entry_pulse, 7 cycles after the final clear (2 + 4 + 1). Expect busy high during the passage and no other pulse.
- Exit, chained: run the reverse order B, AB, A, clear. Expect one exit_pulse. Feed it into smart_parking_lot starting at 3 cars; expect car_count = 2.
- Full: run an entry sequence with lot_full = 1. Expect reject_pulse = 1 and entry_pulse = 0 throughout.
- Bounce and back-out: toggle A every cycle for 3 cycles and then release. Expect da never to change and no pulse. Then go A, AB, A, clear (car backs out). Expect state returns to IDLE with no pulse.
- Timeout and illegal jump: hold A=1,B=1 for 100 cycles from ENT_AB. Expect fault_pulse 64 cycles after entering ENT_AB, busy held in WAIT_CLEAR until both beams clear, then IDLE. Separately, a direct 00 -> 11 jump from IDLE gives fault_pulse.
- Reset mid-operation: assert reset while in ENT_B. Expect all outputs 0 the next cycle and no entry_pulse when the beams later clear.
